// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Purpose: arbitrates the single register-file write port between ALU results
//          and in-order load responses. Outstanding load destinations are held
//          in a DEPTH-entry circular tag FIFO. A per-register pending mask
//          stalls ALU writes to registers that still have a load in flight, so
//          write-after-write ordering is preserved.
//
// Ports:
//   clk            in   clock, all state updates on posedge
//   reset          in   synchronous active-high reset
//   alu_valid      in   ALU result offered
//   alu_rd         in   ALU destination register
//   alu_data       in   ALU result data
//   alu_ready      out  ALU result accepted this cycle
//   ld_issue_valid in   load issued to the cache
//   ld_issue_rd    in   load destination register
//   ld_issue_ready out  tag slot free
//   mem_resp_valid in   load data returned, in issue order, no backpressure
//   mem_resp_data  in   load data
//   reg_wr         out  registered register-file write enable
//   waddr          out  registered register-file write address
//   wdata          out  registered register-file write data
//   pend           out  bit i set while a load to xi is outstanding
//   ld_count       out  number of outstanding loads
//   resp_err       out  sticky: response seen with no outstanding tag
// -----------------------------------------------------------------------------
module writeback_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        ld_issue_valid,
   input  logic [4:0]  ld_issue_rd,
   output logic        ld_issue_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        reg_wr,
   output logic [4:0]  waddr,
   output logic [31:0] wdata,
   output logic [31:0] pend,
   output logic [3:0]  ld_count,
   output logic        resp_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   // Pointers carry one extra wrap bit so full and empty differ in the MSB.
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [4:0]       tags_q [DEPTH];
   logic [31:0]      pend_q, pend_d;
   logic             resp_err_q, resp_err_d;
   logic             reg_wr_q, reg_wr_d;
   logic [4:0]       waddr_q, waddr_d;
   logic [31:0]      wdata_q, wdata_d;

   logic [PTR_W:0]   cnt;
   logic [PTR_W-1:0] wr_idx, rd_idx;
   logic [4:0]       head_rd;
   logic             push, pop, alu_fire, keep_pend;

   assign cnt     = wr_ptr_q - rd_ptr_q;
   assign wr_idx  = wr_ptr_q[PTR_W-1:0];
   assign rd_idx  = rd_ptr_q[PTR_W-1:0];
   assign head_rd = tags_q[rd_idx];

   // Handshakes: nothing is accepted while reset is asserted.
   assign ld_issue_ready = !reset && (cnt != FULL_CNT);
   assign push           = ld_issue_valid && ld_issue_ready;
   assign pop            = !reset && mem_resp_valid && (cnt != '0);
   // Load responses cannot be stalled, so they win the write port; pend_q
   // blocks ALU writes that would overtake an older load to the same register.
   assign alu_ready      = !reset && !pop && !pend_q[alu_rd];
   assign alu_fire       = alu_valid && alu_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(push);
      rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop);
      resp_err_d = resp_err_q || (!reset && mem_resp_valid && (cnt == '0));

      // A popped register stays pending if a younger entry or a same-cycle
      // push still targets it.
      keep_pend = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         if (((PTR_W+1)'(i) < cnt) && (tags_q[rd_idx + PTR_W'(i)] == head_rd))
            keep_pend = 1'b1;
      end
      if (push && (ld_issue_rd == head_rd))
         keep_pend = 1'b1;

      pend_d = pend_q;
      if (pop && !keep_pend)
         pend_d[head_rd] = 1'b0;
      if (push)
         pend_d[ld_issue_rd] = 1'b1;
      pend_d[0] = 1'b0;

      // x0 transfers still consume their slot but never write.
      reg_wr_d = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      if (pop) begin
         reg_wr_d = (head_rd != 5'd0);
         waddr_d  = head_rd;
         wdata_d  = mem_resp_data;
      end else if (alu_fire) begin
         reg_wr_d = (alu_rd != 5'd0);
         waddr_d  = alu_rd;
         wdata_d  = alu_data;
      end
   end

   // ---- registered state / write-port stage ----
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pend_q     <= '0;
         resp_err_q <= 1'b0;
         reg_wr_q   <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pend_q     <= pend_d;
         resp_err_q <= resp_err_d;
         reg_wr_q   <= reg_wr_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         tags_q[wr_idx] <= ld_issue_rd;
   end

   assign reg_wr   = reg_wr_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign pend     = pend_q;
   assign ld_count = 4'(cnt);
   assign resp_err = resp_err_q;

endmodule
